cook_timer_ctrl: RTL and testbench



---
 rtl/cook_timer_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_cook_timer_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cook_timer_ctrl.sv
// Cook-timer controller: synchronized key input, mm:ss BCD countdown, heater gating, done beep.
// Optional COOK_TIMER_ADD30_EN: key_start in IDLE starts 00:30, in COOK adds 30 s (saturating 99:59).
module cook_timer_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned BEEP_SEC = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  input  logic       key_set,
  input  logic       key_start,
  input  logic       key_cancel,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       heat_on,
  output logic       done,
  output logic       err,
  output logic [2:0] state
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   dig_q, dig_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          heat_on_q, heat_on_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Sync vector layout: {in[3:0], door_open, key_cancel, key_start, key_set}
  logic [7:0]    sync1_q, sync2_q;
  logic [2:0]    key_prev_q;

  logic          set_e, start_e, cancel_e, door_s, any_key;
  logic [3:0]    in_s;
  logic          tick, run;
  logic [15:0]   dec;

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

`ifdef COOK_TIMER_ADD30_EN
  function automatic logic [15:0] bcd_add30(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    logic [15:0] r;
    {mt, mo, st, so} = t;
    st = st + 4'd3;
    r  = 16'h9959;
    if (st > 4'd5) begin
      st = st - 4'd6;
      if (mo == 4'd9) begin
        mo = 4'd0;
        if (mt != 4'd9) begin
          mt = mt + 4'd1;
          r  = {mt, mo, st, so};
        end
      end else begin
        mo = mo + 4'd1;
        r  = {mt, mo, st, so};
      end
    end else begin
      r = {mt, mo, st, so};
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      key_prev_q <= '0;
    end else begin
      sync1_q    <= {in, door_open, key_cancel, key_start, key_set};
      sync2_q    <= sync1_q;
      key_prev_q <= sync2_q[2:0];
    end
  end

  assign set_e    = sync2_q[0] & ~key_prev_q[0];
  assign start_e  = sync2_q[1] & ~key_prev_q[1];
  assign cancel_e = sync2_q[2] & ~key_prev_q[2];
  assign door_s   = sync2_q[3];
  assign in_s     = sync2_q[7:4];
  assign any_key  = set_e | start_e | cancel_e;

  assign run  = (state_q == S_COOK) || (state_q == S_DONE);
  assign tick = run && (cnt_q == CW'(TICK_DIV - 1));
  assign dec  = bcd_dec(dig_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dig_q     <= '0;
      cnt_q     <= '0;
      beep_q    <= '0;
      heat_on_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      beep_q    <= beep_d;
      heat_on_q <= heat_on_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    beep_d  = beep_q;
    err_d   = 1'b0;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cancel_e) begin
          dig_d = '0;
`ifdef COOK_TIMER_ADD30_EN
        end else if (start_e) begin
          if (door_s) err_d = 1'b1;
          else begin
            state_d = S_COOK;
            dig_d   = 16'h0030;
          end
`endif
        end else if (set_e && (in_s <= 4'd9)) begin
          dig_d   = {dig_q[11:0], in_s};
          state_d = S_SET;
        end
      end
      S_SET: begin
        if (cancel_e) begin
          dig_d   = '0;
          state_d = S_IDLE;
        end else if (start_e) begin
          if ((dig_q != 16'h0000) && (dig_q[7:4] <= 4'd5) && !door_s) state_d = S_COOK;
          else err_d = 1'b1;
        end else if (set_e && (in_s <= 4'd9)) begin
          dig_d = {dig_q[11:0], in_s};
        end
      end
      S_COOK: begin
        if (door_s || cancel_e) begin
          state_d = S_PAUSE;
`ifdef COOK_TIMER_ADD30_EN
        end else if (start_e) begin
          // A coincident tick is applied before the add so no second is lost
          dig_d = bcd_add30(tick ? dec : dig_q);
`endif
        end else if (tick) begin
          dig_d = dec;
          if (dec == 16'h0000) state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (cancel_e) begin
          dig_d   = '0;
          state_d = S_IDLE;
        end else if (start_e) begin
          if (door_s) err_d = 1'b1;
          else state_d = S_COOK;
        end
      end
      S_DONE: begin
        dig_d = '0;
        if (any_key || (tick && (beep_q == BW'(BEEP_SEC - 1)))) state_d = S_IDLE;
        else if (tick) beep_d = beep_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        dig_d   = '0;
      end
    endcase
    // Prescaler only keeps running across COOK/DONE; any entry into COOK restarts a full second
    if (run && ((state_d == S_COOK) || (state_d == S_DONE)))
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (state_d != S_DONE) beep_d = '0;
  end

  // Output decode (registered against next state)
  always_comb begin
    heat_on_d = (state_d == S_COOK);
    done_d    = (state_d == S_DONE);
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = dig_q;
  assign heat_on = heat_on_q;
  assign done    = done_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed self-checking bench for cook_timer_ctrl (TICK_DIV=4, BEEP_SEC=3).
module tb_cook_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_v = 4'd0;
  logic       key_set = 1'b0, key_start = 1'b0, key_cancel = 1'b0, door_open = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       heat_on, done, err;
  logic [2:0] state;
  logic [15:0] disp;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  localparam int K_SET = 0, K_START = 1, K_CANCEL = 2;

  cook_timer_ctrl #(.TICK_DIV(4), .BEEP_SEC(3)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_v),
    .key_set(key_set), .key_start(key_start), .key_cancel(key_cancel), .door_open(door_open),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .heat_on(heat_on), .done(done), .err(err), .state(state)
  );

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge right after the action edge
  task automatic press(input int k);
    case (k)
      K_SET:    key_set = 1'b1;
      K_START:  key_start = 1'b1;
      default:  key_cancel = 1'b1;
    endcase
    wait_cyc(3);
    key_set = 1'b0;
    key_start = 1'b0;
    key_cancel = 1'b0;
  endtask

  task automatic enter(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) begin
      in_v = v[i*4 +: 4];
      press(K_SET);
      wait_cyc(1);
    end
  endtask

  task automatic clear_all();
    press(K_CANCEL);
    wait_cyc(1);
    press(K_CANCEL);
    wait_cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_state", state, 3'd0);
    check("rst_disp", disp, 16'h0000);
    check("rst_heat", heat_on, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    wait_cyc(2);

    // key_start in IDLE
    press(K_START);
`ifdef COOK_TIMER_ADD30_EN
    check("add30_idle_state", state, 3'd2);
    check("add30_idle_disp", disp, 16'h0030);
    clear_all();
`else
    check("idle_start_ignored", state, 3'd0);
    wait_cyc(1);
`endif

    // 12:05 countdown
    enter(16'h1205);
    check("set_state", state, 3'd1);
    check("set_disp", disp, 16'h1205);
    press(K_START);
    check("cook_state", state, 3'd2);
    check("cook_heat", heat_on, 1'b1);
    check("cook_disp0", disp, 16'h1205);
    wait_cyc(3);
    check("cook_disp_pre_tick", disp, 16'h1205);
    wait_cyc(1);
    check("cook_disp_1204", disp, 16'h1204);
    wait_cyc(16);
    check("cook_disp_1200", disp, 16'h1200);
    wait_cyc(4);
    check("cook_disp_1159", disp, 16'h1159);
    press(K_CANCEL);
    check("cancel_pause_state", state, 3'd3);
    check("cancel_pause_disp", disp, 16'h1159);
    check("pause_heat", heat_on, 1'b0);
    wait_cyc(1);
    press(K_CANCEL);
    check("cancel_idle_state", state, 3'd0);
    check("cancel_idle_disp", disp, 16'h0000);
    wait_cyc(1);

    // 00:02 to DONE and auto-return
    enter(16'h0002);
    press(K_START);
    wait_cyc(4);
    check("short_disp_0001", disp, 16'h0001);
    wait_cyc(4);
    check("done_state", state, 3'd4);
    check("done_flag", done, 1'b1);
    check("done_heat", heat_on, 1'b0);
    check("done_disp", disp, 16'h0000);
    wait_cyc(11);
    check("done_hold", state, 3'd4);
    wait_cyc(1);
    check("done_to_idle", state, 3'd0);
    check("done_cleared", done, 1'b0);
    wait_cyc(1);

    // Rejected starts
    enter(16'h0070);
    press(K_START);
    check("bad_st_err", err, 1'b1);
    check("bad_st_state", state, 3'd1);
    wait_cyc(1);
    check("err_one_cycle", err, 1'b0);
    press(K_CANCEL);
    wait_cyc(1);
    in_v = 4'd0;
    press(K_SET);
    wait_cyc(1);
    check("zero_set_state", state, 3'd1);
    press(K_START);
    check("zero_start_err", err, 1'b1);
    check("zero_start_state", state, 3'd1);
    press(K_CANCEL);
    wait_cyc(1);

    // Door pause and resume
    enter(16'h0010);
    press(K_START);
    door_open = 1'b1;
    wait_cyc(2);
    check("door_pre_state", state, 3'd2);
    check("door_pre_heat", heat_on, 1'b1);
    wait_cyc(1);
    check("door_pause_state", state, 3'd3);
    check("door_pause_heat", heat_on, 1'b0);
    check("door_pause_disp", disp, 16'h0010);
    press(K_START);
    check("door_open_start_err", err, 1'b1);
    check("door_open_start_state", state, 3'd3);
    door_open = 1'b0;
    wait_cyc(3);
    press(K_START);
    check("resume_state", state, 3'd2);
    check("resume_disp", disp, 16'h0010);
    wait_cyc(3);
    check("resume_pre_tick", disp, 16'h0010);
    wait_cyc(1);
    check("resume_tick", disp, 16'h0009);
    clear_all();

    // Asynchronous reset mid-cook
    enter(16'h0105);
    press(K_START);
    wait_cyc(1);
    check("pre_rst_disp", disp, 16'h0105);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", state, 3'd0);
    check("async_rst_heat", heat_on, 1'b0);
    check("async_rst_disp", disp, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(2);

`ifdef COOK_TIMER_ADD30_EN
    enter(16'h0045);
    press(K_START);
    press(K_START);
    check("add30_0045", disp, 16'h0115);
    clear_all();
    enter(16'h9940);
    press(K_START);
    press(K_START);
    check("add30_sat", disp, 16'h9959);
    clear_all();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
